// File: rtl/packet_store_fwd_if.sv
// Valid/ready/last word stream used on both sides of the store-and-forward buffer.
interface packet_store_fwd_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] stream;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output stream, output valid, output last, input ready);
    modport slave  (input stream, input valid, input last, output ready);
endinterface

// File: rtl/packet_store_fwd.sv
// Multi-slot store-and-forward packet buffer: whole packets in, replayed in arrival order
// with destination address and length sideband; oversize packets are dropped and counted.
module packet_store_fwd #(
    parameter  int DATA_W    = 32,
    parameter  int MAX_LEN   = 256,
    parameter  int NUM_SLOTS = 4,
    parameter  int ADDR_W    = 48,
    localparam int LEN_W     = $clog2(MAX_LEN + 1),
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    packet_store_fwd_if.slave   rx,
    packet_store_fwd_if.master  tx,
    output logic [ADDR_W-1:0]   dest_addr,
    output logic [LEN_W-1:0]    pkt_len,
    output logic [CNT_W-1:0]    pkts_stored,
    output logic [15:0]         drop_count
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int MEM_D  = NUM_SLOTS * MAX_LEN;
    localparam int MEM_AW = $clog2(MEM_D);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wr_state_t;
    typedef enum logic       {R_IDLE, R_SEND} rd_state_t;

    wr_state_t          wr_state, wr_state_nx;
    logic [SLOT_W-1:0]  wr_slot;
    logic [LEN_W-1:0]   wr_len;
    logic [DATA_W-1:0]  word0, word1;
    logic               ready_q;
    logic [CNT_W-1:0]   count, count_nx;

    rd_state_t          rd_state;
    logic [SLOT_W-1:0]  rd_slot;
    logic [LEN_W-1:0]   rd_idx;

    logic [DATA_W-1:0]  mem       [MEM_D];
    logic [ADDR_W-1:0]  meta_addr [NUM_SLOTS];
    logic [LEN_W-1:0]   meta_len  [NUM_SLOTS];

    logic                rx_fire, tx_fire, commit, rel_pkt, drop, mem_we, send;
    logic [MEM_AW-1:0]   mem_wa, mem_ra;
    logic [2*DATA_W-1:0] addr_cat;
    logic [LEN_W-1:0]    commit_len;

    assign rx_fire    = rx.valid & ready_q;
    assign tx_fire    = tx.valid & tx.ready;
    assign rel_pkt    = tx_fire & tx.last;
    assign mem_wa     = MEM_AW'(wr_slot) * MEM_AW'(MAX_LEN) + MEM_AW'(wr_len);
    assign mem_ra     = MEM_AW'(rd_slot) * MEM_AW'(MAX_LEN) + MEM_AW'(rd_idx);
    assign commit_len = wr_len + LEN_W'(1);
    assign count_nx   = count + CNT_W'(commit) - CNT_W'(rel_pkt);

    // wr_len counts words already stored, so it doubles as the in-slot write offset
    always_comb begin
        wr_state_nx = wr_state;
        commit      = 1'b0;
        drop        = 1'b0;
        mem_we      = 1'b0;
        addr_cat    = {word0, word1};
        case (wr_state)
            W_IDLE: begin
                if (rx_fire) begin
                    mem_we = 1'b1;
                    if (rx.last) begin
                        commit   = 1'b1;
                        addr_cat = {rx.stream, {DATA_W{1'b0}}};
                    end else begin
                        wr_state_nx = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (rx_fire) begin
                    if (wr_len == LEN_W'(MAX_LEN)) begin
                        if (rx.last) begin
                            drop        = 1'b1;
                            wr_state_nx = W_IDLE;
                        end else begin
                            wr_state_nx = W_DISCARD;
                        end
                    end else begin
                        mem_we = 1'b1;
                        if (rx.last) begin
                            commit      = 1'b1;
                            wr_state_nx = W_IDLE;
                            addr_cat    = {word0, (wr_len == LEN_W'(1)) ? rx.stream : word1};
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (rx_fire && rx.last) begin
                    drop        = 1'b1;
                    wr_state_nx = W_IDLE;
                end
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state   <= W_IDLE;
            wr_slot    <= '0;
            wr_len     <= '0;
            word0      <= '0;
            word1      <= '0;
            ready_q    <= 1'b0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            wr_state <= wr_state_nx;
            count    <= count_nx;
            // a packet already in progress is never stalled; only a new first beat waits for a slot
            ready_q  <= (wr_state_nx != W_IDLE) || (count_nx < CNT_W'(NUM_SLOTS));
            if (rx_fire) begin
                if (wr_state == W_IDLE) begin
                    word0 <= rx.stream;
                    word1 <= '0;
                end else if (wr_state == W_FILL && wr_len == LEN_W'(1)) begin
                    word1 <= rx.stream;
                end
                wr_len <= (wr_state_nx == W_FILL) ? wr_len + LEN_W'(1) : '0;
            end
            if (commit)
                wr_slot <= wr_slot + SLOT_W'(1);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= rx.stream;
        if (commit) begin
            meta_addr[wr_slot] <= addr_cat[2*DATA_W-1 -: ADDR_W];
            meta_len[wr_slot]  <= commit_len;
        end
    end

    // using count_nx lets the read side start in the same cycle the commit becomes visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            rd_slot  <= '0;
            rd_idx   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (count_nx != '0) begin
                        rd_state <= R_SEND;
                        rd_idx   <= '0;
                    end
                end
                R_SEND: begin
                    if (tx_fire) begin
                        if (tx.last) begin
                            rd_slot <= rd_slot + SLOT_W'(1);
                            rd_idx  <= '0;
                            if (count_nx == '0)
                                rd_state <= R_IDLE;
                        end else begin
                            rd_idx <= rd_idx + LEN_W'(1);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign send        = (rd_state == R_SEND);
    assign rx.ready    = ready_q;
    assign tx.valid    = send;
    assign tx.stream   = send ? mem[mem_ra] : '0;
    assign tx.last     = send && (rd_idx == meta_len[rd_slot] - LEN_W'(1));
    assign dest_addr   = send ? meta_addr[rd_slot] : '0;
    assign pkt_len     = send ? meta_len[rd_slot] : '0;
    assign pkts_stored = count;
endmodule

// File: tb/tb_packet_store_fwd.sv
// Randomized scoreboard bench for packet_store_fwd: a packet-level model queues expected
// words at issue time; an independent monitor pops and compares on every output transfer.
module tb_packet_store_fwd;
    localparam int DATA_W    = 32;
    localparam int MAX_LEN   = 16;
    localparam int NUM_SLOTS = 4;
    localparam int ADDR_W    = 48;
    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    packet_store_fwd_if #(.DATA_W(DATA_W)) rx ();
    packet_store_fwd_if #(.DATA_W(DATA_W)) tx ();
    logic [ADDR_W-1:0] dest_addr;
    logic [LEN_W-1:0]  pkt_len;
    logic [CNT_W-1:0]  pkts_stored;
    logic [15:0]       drop_count;

    packet_store_fwd #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
        .dest_addr(dest_addr), .pkt_len(pkt_len),
        .pkts_stored(pkts_stored), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;
    int rdy_pct = 100;

    logic [DATA_W-1:0] exp_data [$];
    logic              exp_last [$];
    logic [LEN_W-1:0]  exp_len  [$];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] pkt_words [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // sink ready throttling
    initial begin
        tx.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx.ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // monitor: scoreboard pop on each transfer, plus hold-stability under backpressure
    logic              hold = 1'b0;
    logic [DATA_W-1:0] h_data;
    logic              h_last;
    logic [LEN_W-1:0]  h_len;
    logic [ADDR_W-1:0] h_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_word", 64'({tx.valid, tx.last, tx.stream}), 64'({1'b1, h_last, h_data}));
                check("hold_side", 64'({pkt_len, dest_addr}), 64'({h_len, h_addr}));
            end
            if (tx.valid && tx.ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got word %0h, expected no output", tx.stream);
                end else begin
                    check("out_data", 64'(tx.stream), 64'(exp_data.pop_front()));
                    check("out_last", 64'(tx.last),   64'(exp_last.pop_front()));
                    check("out_len",  64'(pkt_len),   64'(exp_len.pop_front()));
                    check("out_addr", 64'(dest_addr), 64'(exp_addr.pop_front()));
                end
            end
            hold   = tx.valid && !tx.ready;
            h_data = tx.stream;
            h_last = tx.last;
            h_len  = pkt_len;
            h_addr = dest_addr;
        end
    end

    task automatic drive_word(input logic [DATA_W-1:0] d, input bit l, input int idle_pct,
                              input bit must_ready);
        int waited = 0;
        while ($urandom_range(99) < idle_pct) begin
            rx.valid = 1'b0;
            @(posedge clk);
            #1;
        end
        rx.valid  = 1'b1;
        rx.stream = d;
        rx.last   = l;
        @(negedge clk);
        if (must_ready)
            check("in_ready_held", 64'(rx.ready), 64'(1));
        while (!rx.ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!rx.ready) begin
            checks++;
            errors++;
            $display("FAIL in_timeout: ready stuck at 0, required 1");
        end
        @(posedge clk);
        #1;
        rx.valid = 1'b0;
        rx.last  = 1'b0;
    endtask

    // packet-level model: legal packets are replayed verbatim, oversize ones vanish and count
    task automatic send_pkt(input int idle_pct, input bit must_ready);
        int n = pkt_words.size();
        logic [63:0] cat;
        if (n > MAX_LEN) begin
            exp_drops++;
        end else begin
            cat = {pkt_words[0], (n > 1) ? pkt_words[1] : 32'h0};
            for (int i = 0; i < n; i++) begin
                exp_data.push_back(pkt_words[i]);
                exp_last.push_back(i == n - 1);
                exp_len.push_back(LEN_W'(n));
                exp_addr.push_back(cat[63:16]);
            end
        end
        for (int i = 0; i < n; i++)
            drive_word(pkt_words[i], (i == n - 1), idle_pct, must_ready);
    endtask

    task automatic rand_pkt(input int n);
        pkt_words.delete();
        for (int i = 0; i < n; i++)
            pkt_words.push_back($urandom());
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_data.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (exp_data.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words left, expected 0", exp_data.size());
        end
        @(posedge clk);
        #1;
        check("pkts_stored_drained", 64'(pkts_stored), 64'(0));
    endtask

    task automatic check_zero();
        check("rst_valid", 64'(tx.valid),    64'(0));
        check("rst_ready", 64'(rx.ready),    64'(0));
        check("rst_data",  64'(tx.stream),   64'(0));
        check("rst_last",  64'(tx.last),     64'(0));
        check("rst_addr",  64'(dest_addr),   64'(0));
        check("rst_len",   64'(pkt_len),     64'(0));
        check("rst_count", 64'(pkts_stored), 64'(0));
        check("rst_drops", 64'(drop_count),  64'(0));
    endtask

    initial begin
        int gaps;
        rx.valid  = 1'b0;
        rx.stream = '0;
        rx.last   = 1'b0;
        #22;
        check_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 3-word packet: visible one cycle after the last beat
        pkt_words = {32'h0011_2233, 32'h4455_6677, 32'h8899_AABB};
        send_pkt(0, 0);
        check("t1_valid", 64'(tx.valid),    64'(1));
        check("t1_addr",  64'(dest_addr),   64'(48'h0011_2233_4455));
        check("t1_len",   64'(pkt_len),     64'(3));
        check("t1_count", 64'(pkts_stored), 64'(1));
        wait_drain();

        // single-word packet
        pkt_words = {32'hDEAD_BEEF};
        send_pkt(0, 0);
        check("t2_valid", 64'(tx.valid),  64'(1));
        check("t2_last",  64'(tx.last),   64'(1));
        check("t2_len",   64'(pkt_len),   64'(1));
        check("t2_addr",  64'(dest_addr), 64'(48'hDEAD_BEEF_0000));
        wait_drain();

        // oversize drops and the exact-MAX_LEN boundary
        rand_pkt(MAX_LEN + 5); send_pkt(0, 1);
        rand_pkt(2);           send_pkt(0, 1);
        wait_drain();
        check("t3_drops", 64'(drop_count), 64'(1));
        rand_pkt(MAX_LEN);     send_pkt(0, 1);
        rand_pkt(MAX_LEN + 1); send_pkt(0, 1);
        wait_drain();
        check("t3_drops_b", 64'(drop_count), 64'(exp_drops));

        // fill all slots under backpressure, then drain back-to-back
        rdy_pct = 0;
        @(posedge clk);
        #1;
        rand_pkt(3); send_pkt(0, 0);
        rand_pkt(5); send_pkt(0, 0);
        rand_pkt(2); send_pkt(0, 0);
        rand_pkt(4); send_pkt(0, 0);
        check("t4_full_count", 64'(pkts_stored), 64'(NUM_SLOTS));
        rand_pkt(6);
        gaps = 0;
        fork
            send_pkt(0, 0);
            begin
                repeat (3) @(negedge clk);
                check("t4_full_stall", 64'({rx.valid, rx.ready}), 64'(2'b10));
                rdy_pct = 100;
                @(posedge clk);
                repeat (14) begin
                    @(negedge clk);
                    if (!tx.valid) gaps++;
                end
                check("t4_back_to_back_gaps", 64'(gaps), 64'(0));
            end
        join
        wait_drain();

        // random traffic with throttling on both sides
        rdy_pct = 60;
        for (int p = 0; p < 1000; p++) begin
            rand_pkt($urandom_range(1, MAX_LEN));
            send_pkt(30, 0);
        end
        wait_drain();
        check("t5_drops", 64'(drop_count), 64'(exp_drops));

        // reset with a packet on the output and another half received
        rdy_pct = 0;
        @(posedge clk);
        #1;
        rand_pkt(4);
        send_pkt(0, 0);
        for (int i = 0; i < 3; i++)
            drive_word($urandom(), 1'b0, 0, 0);
        rx.valid  = 1'b1;
        rx.stream = $urandom();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero();
        exp_data.delete();
        exp_last.delete();
        exp_len.delete();
        exp_addr.delete();
        exp_drops = 0;
        rx.valid  = 1'b0;
        rx.last   = 1'b0;
        rdy_pct   = 100;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rand_pkt(5);
        send_pkt(0, 0);
        check("t6_len", 64'(pkt_len), 64'(5));
        wait_drain();
        check("t6_drops", 64'(drop_count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
